id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage.sv | 163 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32I core: captures the decoded bundle,
// interlocks load-use pairs with a one-cycle bubble and honours EX redirects.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            valid_d,
  input  logic            reg_write_d,
  input  logic            mem_write_d,
  input  logic            branch_d,
  input  logic            jump_d,
  input  logic            alu_src_d,
  input  logic [1:0]      result_src_d,
  input  logic [1:0]      alu_op_d,
  input  logic [1:0]      imm_src_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] imm_ext_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,

  input  logic            pcsrc_e,

  output logic            valid_e,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic            alu_src_e,
  output logic [1:0]      result_src_e,
  output logic [1:0]      alu_op_e,
  output logic [1:0]      imm_src_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc_plus4_e,

  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [1:0]      alu_op;
    logic [1:0]      imm_src;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } ex_bundle_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ex_bundle_t       w_d_bundle;
  ex_bundle_t       r_e;
  logic             w_lw_hazard;
  logic             w_stall;
  logic             w_bubble;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_comb begin
    w_d_bundle            = '0;
    w_d_bundle.valid      = 1'b1;
    w_d_bundle.reg_write  = reg_write_d;
    w_d_bundle.mem_write  = mem_write_d;
    w_d_bundle.branch     = branch_d;
    w_d_bundle.jump       = jump_d;
    w_d_bundle.alu_src    = alu_src_d;
    w_d_bundle.result_src = result_src_d;
    w_d_bundle.alu_op     = alu_op_d;
    w_d_bundle.imm_src    = imm_src_d;
    w_d_bundle.rs1        = rs1_d;
    w_d_bundle.rs2        = rs2_d;
    w_d_bundle.rd         = rd_d;
    w_d_bundle.rd1        = rd1_d;
    w_d_bundle.rd2        = rd2_d;
    w_d_bundle.imm_ext    = imm_ext_d;
    w_d_bundle.pc         = pc_d;
    w_d_bundle.pc_plus4   = pc_plus4_d;
  end

  // A load in E (result_src 01) whose non-x0 destination feeds the D instruction.
  assign w_lw_hazard = valid_d & r_e.valid & r_e.reg_write &
                       (r_e.result_src == 2'b01) & (r_e.rd != 5'd0) &
                       ((r_e.rd == rs1_d) | (r_e.rd == rs2_d));

  // Redirect beats the interlock so the branch target is never held off.
  assign w_stall  = w_lw_hazard & ~pcsrc_e;
  assign w_bubble = pcsrc_e | w_lw_hazard | ~valid_d;

  assign stall_f = w_stall;
  assign stall_d = w_stall;
  assign flush_d = pcsrc_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e <= '0;
    end else if (w_bubble) begin
      r_e <= '0;
    end else begin
      r_e <= w_d_bundle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (pcsrc_e && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign valid_e      = r_e.valid;
  assign reg_write_e  = r_e.reg_write;
  assign mem_write_e  = r_e.mem_write;
  assign branch_e     = r_e.branch;
  assign jump_e       = r_e.jump;
  assign alu_src_e    = r_e.alu_src;
  assign result_src_e = r_e.result_src;
  assign alu_op_e     = r_e.alu_op;
  assign imm_src_e    = r_e.imm_src;
  assign rs1_e        = r_e.rs1;
  assign rs2_e        = r_e.rs2;
  assign rd_e         = r_e.rd;
  assign rd1_e        = r_e.rd1;
  assign rd2_e        = r_e.rd2;
  assign imm_ext_e    = r_e.imm_ext;
  assign pc_e         = r_e.pc;
  assign pc_plus4_e   = r_e.pc_plus4;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed pipeline scenarios plus random traffic,
// checked every cycle against a bundle-level model of the E register.
module tb_id_ex_stage;

  localparam int XLEN = 32;

  typedef struct packed {
    logic        valid, reg_write, mem_write, branch, jump, alu_src;
    logic [1:0]  result_src, alu_op, imm_src;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm, pc, pcp4;
  } bundle_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_d, reg_write_d, mem_write_d, branch_d, jump_d, alu_src_d, pcsrc_e;
  logic [1:0]  result_src_d, alu_op_d, imm_src_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d;

  logic valid_e, reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e;
  logic [1:0]  result_src_e, alu_op_e, imm_src_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic stall_f, stall_d, flush_d;
  logic [15:0] stall_cnt, flush_cnt;

  logic s_valid_e, s_reg_write_e, s_mem_write_e, s_branch_e, s_jump_e, s_alu_src_e;
  logic [1:0]  s_result_src_e, s_alu_op_e, s_imm_src_e;
  logic [4:0]  s_rs1_e, s_rs2_e, s_rd_e;
  logic [31:0] s_rd1_e, s_rd2_e, s_imm_ext_e, s_pc_e, s_pc_plus4_e;
  logic s_stall_f, s_stall_d, s_flush_d;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .reg_write_d(reg_write_d),
    .mem_write_d(mem_write_d), .branch_d(branch_d), .jump_d(jump_d), .alu_src_d(alu_src_d),
    .result_src_d(result_src_d), .alu_op_d(alu_op_d), .imm_src_d(imm_src_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .pcsrc_e(pcsrc_e),
    .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .jump_e(jump_e), .alu_src_e(alu_src_e),
    .result_src_e(result_src_e), .alu_op_e(alu_op_e), .imm_src_e(imm_src_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  id_ex_stage #(.XLEN(XLEN), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .reg_write_d(reg_write_d),
    .mem_write_d(mem_write_d), .branch_d(branch_d), .jump_d(jump_d), .alu_src_d(alu_src_d),
    .result_src_d(result_src_d), .alu_op_d(alu_op_d), .imm_src_d(imm_src_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .pcsrc_e(pcsrc_e),
    .valid_e(s_valid_e), .reg_write_e(s_reg_write_e), .mem_write_e(s_mem_write_e),
    .branch_e(s_branch_e), .jump_e(s_jump_e), .alu_src_e(s_alu_src_e),
    .result_src_e(s_result_src_e), .alu_op_e(s_alu_op_e), .imm_src_e(s_imm_src_e),
    .rs1_e(s_rs1_e), .rs2_e(s_rs2_e), .rd_e(s_rd_e), .rd1_e(s_rd1_e), .rd2_e(s_rd2_e),
    .imm_ext_e(s_imm_ext_e), .pc_e(s_pc_e), .pc_plus4_e(s_pc_plus4_e),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_d(s_flush_d),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  int      n_vec = 0;
  int      n_err = 0;
  bundle_t m_e;
  int      m_stall, m_flush;
  bit      last_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bundle_t d_bundle();
    bundle_t b;
    b = '{valid: 1'b1, reg_write: reg_write_d, mem_write: mem_write_d, branch: branch_d,
          jump: jump_d, alu_src: alu_src_d, result_src: result_src_d, alu_op: alu_op_d,
          imm_src: imm_src_d, rs1: rs1_d, rs2: rs2_d, rd: rd_d, rd1: rd1_d, rd2: rd2_d,
          imm: imm_ext_d, pc: pc_d, pcp4: pc_plus4_d};
    return b;
  endfunction

  // Load in E whose real destination is read by a real instruction in D.
  function automatic bit model_haz();
    return valid_d && m_e.valid && m_e.reg_write && (m_e.result_src == 2'b01) &&
           (m_e.rd != 5'd0) && (m_e.rd == rs1_d || m_e.rd == rs2_d);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_e = '0;
    m_stall = 0;
    m_flush = 0;
    last_stall = 1'b0;
  endtask

  task automatic step();
    bundle_t nx;
    bit      haz, st, fl;
    haz = model_haz();
    fl  = pcsrc_e;
    st  = haz && !fl;
    if (fl || haz || !valid_d) nx = '0;
    else nx = d_bundle();
    @(posedge clk);
    m_e = nx;
    if (st) m_stall++;
    if (fl) m_flush++;
    last_stall = st;
    #1;
  endtask

  task automatic check_all();
    bit st;
    #1;
    st = model_haz() && !pcsrc_e;
    chk("valid_e", 32'(valid_e), 32'(m_e.valid));
    chk("reg_write_e", 32'(reg_write_e), 32'(m_e.reg_write));
    chk("mem_write_e", 32'(mem_write_e), 32'(m_e.mem_write));
    chk("branch_e", 32'(branch_e), 32'(m_e.branch));
    chk("jump_e", 32'(jump_e), 32'(m_e.jump));
    chk("alu_src_e", 32'(alu_src_e), 32'(m_e.alu_src));
    chk("result_src_e", 32'(result_src_e), 32'(m_e.result_src));
    chk("alu_op_e", 32'(alu_op_e), 32'(m_e.alu_op));
    chk("imm_src_e", 32'(imm_src_e), 32'(m_e.imm_src));
    chk("rs1_e", 32'(rs1_e), 32'(m_e.rs1));
    chk("rs2_e", 32'(rs2_e), 32'(m_e.rs2));
    chk("rd_e", 32'(rd_e), 32'(m_e.rd));
    chk("rd1_e", rd1_e, m_e.rd1);
    chk("rd2_e", rd2_e, m_e.rd2);
    chk("imm_ext_e", imm_ext_e, m_e.imm);
    chk("pc_e", pc_e, m_e.pc);
    chk("pc_plus4_e", pc_plus4_e, m_e.pcp4);
    chk("stall_f", 32'(stall_f), 32'(st));
    chk("stall_d", 32'(stall_d), 32'(st));
    chk("flush_d", 32'(flush_d), 32'(pcsrc_e));
    chk("stall_cnt", 32'(stall_cnt), 32'(sat(m_stall, 65535)));
    chk("flush_cnt", 32'(flush_cnt), 32'(sat(m_flush, 65535)));
    chk("s_bundle", {s_valid_e, s_reg_write_e, s_mem_write_e, s_branch_e, s_jump_e,
                     s_alu_src_e, s_result_src_e, s_alu_op_e, s_imm_src_e, s_rs1_e,
                     s_rs2_e, s_rd_e}, {m_e.valid, m_e.reg_write, m_e.mem_write,
                     m_e.branch, m_e.jump, m_e.alu_src, m_e.result_src, m_e.alu_op,
                     m_e.imm_src, m_e.rs1, m_e.rs2, m_e.rd});
    chk("s_data", s_rd1_e ^ s_rd2_e ^ s_imm_ext_e ^ s_pc_e ^ s_pc_plus4_e,
        m_e.rd1 ^ m_e.rd2 ^ m_e.imm ^ m_e.pc ^ m_e.pcp4);
    chk("s_hazard", {29'd0, s_stall_f, s_stall_d, s_flush_d}, {29'd0, st, st, pcsrc_e});
    chk("s_stall_cnt", 32'(s_stall_cnt), 32'(sat(m_stall, 3)));
    chk("s_flush_cnt", 32'(s_flush_cnt), 32'(sat(m_flush, 3)));
  endtask

  task automatic rand_data();
    branch_d   = 1'($urandom);
    jump_d     = 1'($urandom);
    alu_src_d  = 1'($urandom);
    imm_src_d  = 2'($urandom);
    rd1_d      = $urandom;
    rd2_d      = $urandom;
    imm_ext_d  = $urandom;
    pc_d       = $urandom & 32'hFFFF_FFFC;
    pc_plus4_d = pc_d + 32'd4;
  endtask

  task automatic set_d(input bit v, input bit rw, input bit mw, input logic [1:0] rs,
                       input logic [1:0] aop, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rdd);
    rand_data();
    valid_d = v; reg_write_d = rw; mem_write_d = mw; result_src_d = rs;
    alu_op_d = aop; rs1_d = r1; rs2_d = r2; rd_d = rdd;
    branch_d = 1'b0; jump_d = 1'b0;
  endtask

  task automatic rand_d();
    pcsrc_e = ($urandom_range(0, 7) == 0);
    if (last_stall) return;
    rand_data();
    valid_d      = ($urandom_range(0, 9) != 0);
    reg_write_d  = 1'($urandom);
    mem_write_d  = 1'($urandom);
    result_src_d = 2'($urandom);
    alu_op_d     = 2'($urandom);
    rs1_d        = 5'($urandom_range(0, 7));
    rs2_d        = 5'($urandom_range(0, 7));
    rd_d         = 5'($urandom_range(0, 7));
  endtask

  task automatic reset_pulse();
    rand_d();
    valid_d = 1'b1;
    pcsrc_e = 1'b0;
    check_all();
    rst_n = 1'b0;
    #1;
    chk("rst_valid_e", 32'(valid_e), 32'd0);
    chk("rst_bundle", {reg_write_e, mem_write_e, result_src_e, alu_op_e, rd_e, rs1_e, rs2_e},
        32'd0);
    chk("rst_pc_e", pc_e | rd1_e | imm_ext_e, 32'd0);
    chk("rst_cnts", {stall_cnt, flush_cnt}, 32'd0);
    chk("rst_stall_d", 32'(stall_d), 32'd0);
    model_reset();
    check_all();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    model_reset();
    set_d(1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 5'd1, 5'd2, 5'd3);
    pcsrc_e = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("init_valid_e", 32'(valid_e), 32'd0);
    chk("init_cnt", {stall_cnt, flush_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    // Straight-line: ALU op into x5.
    set_d(1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 5'd1, 5'd2, 5'd5);
    check_all();
    step();
    set_d(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
    check_all();
    chk("addi_reg_write_e", 32'(reg_write_e), 32'd1);
    chk("addi_alu_op_e", 32'(alu_op_e), 32'd2);
    chk("addi_rd_e", 32'(rd_e), 32'd5);
    chk("addi_valid_e", 32'(valid_e), 32'd1);
    chk("addi_stall_d", 32'(stall_d), 32'd0);
    step();

    // Load-use on x6 via rs2.
    set_d(1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 5'd1, 5'd0, 5'd6);
    check_all();
    step();
    set_d(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 5'd2, 5'd6, 5'd7);
    check_all();
    chk("lu_stall_d", 32'(stall_d), 32'd1);
    chk("lu_stall_f", 32'(stall_f), 32'd1);
    step();
    check_all();
    chk("lu_bubble_valid_e", 32'(valid_e), 32'd0);
    chk("lu_stall_once", 32'(stall_d), 32'd0);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    step();
    set_d(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
    check_all();
    chk("lu_add_rd_e", 32'(rd_e), 32'd7);
    chk("lu_add_valid_e", 32'(valid_e), 32'd1);
    step();

    // Load to x0 never interlocks.
    set_d(1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 5'd3, 5'd4, 5'd0);
    check_all();
    step();
    set_d(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd8);
    check_all();
    chk("x0_stall_d", 32'(stall_d), 32'd0);
    step();
    check_all();
    chk("x0_rd_e", 32'(rd_e), 32'd8);
    chk("x0_valid_e", 32'(valid_e), 32'd1);

    // Redirect with a store in D.
    set_d(1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 5'd9, 5'd10, 5'd0);
    pcsrc_e = 1'b1;
    check_all();
    chk("fl_flush_d", 32'(flush_d), 32'd1);
    step();
    pcsrc_e = 1'b0;
    check_all();
    chk("fl_mem_write_e", 32'(mem_write_e), 32'd0);
    chk("fl_valid_e", 32'(valid_e), 32'd0);
    chk("fl_flush_cnt", 32'(flush_cnt), 32'd1);

    // Six load-use pairs: 2-bit counter pins at 3.
    for (int i = 0; i < 6; i++) begin
      set_d(1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 5'd1, 5'd2, 5'd6);
      check_all();
      step();
      set_d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd6, 5'd3, 5'd9);
      check_all();
      step();
      check_all();
      if (i == 4) begin
        chk("sat_s_stall_cnt5", 32'(s_stall_cnt), 32'd3);
        chk("sat_stall_cnt5", 32'(stall_cnt), 32'd6);
      end
    end
    chk("sat_s_stall_hold", 32'(s_stall_cnt), 32'd3);
    chk("sat_stall_cnt7", 32'(stall_cnt), 32'd7);

    reset_pulse();

    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) reset_pulse();
      rand_d();
      check_all();
      step();
    end
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
